// File: rtl/formula_result_collector_if.sv
// Collector bus: pipe launch/result beats plus the downstream valid/ready head.
// slave is the collector's own view; master is the surrounding environment.
interface formula_result_collector_if #(
    parameter int width = 32
);
    logic             arg_vld;
    logic             arg_rdy;
    logic             res_vld;
    logic [width-1:0] res;
    logic             out_vld;
    logic [width-1:0] out_data;
    logic             out_rdy;
    logic             overflow;
    logic             proto_err;

    modport slave (
        input  arg_vld, res_vld, res, out_rdy,
        output arg_rdy, out_vld, out_data, overflow, proto_err
    );

    modport master (
        output arg_vld, res_vld, res, out_rdy,
        input  arg_rdy, out_vld, out_data, overflow, proto_err
    );
endinterface

// File: rtl/formula_result_collector.sv
// Credit-gated result FIFO behind a fixed-latency formula pipe.
// FORMULA_COLLECTOR_CHECK_EN adds in-flight tracking and sticky error flags.
module formula_result_collector #(
    parameter int width = 32,
    parameter int depth = 16
) (
    input  logic clk,
    input  logic rst,
    formula_result_collector_if.slave bus
);
    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);

    logic [CW-1:0]    credits_q, credits_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];

    logic arg_rdy, full, empty, launch, pop, push;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW])
               && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        arg_rdy = (credits_q != '0);
        launch  = bus.arg_vld & arg_rdy;
        pop     = !empty & bus.out_rdy;
        // a full FIFO still accepts a beat when the head leaves this cycle
        push    = bus.res_vld & (!full | pop);
    end

    always_comb begin
        credits_d = credits_q;
        unique case ({launch, pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = bus.res;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_q <= CW'(depth);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_q     <= '{default: '0};
        end else begin
            credits_q <= credits_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_q     <= mem_d;
        end
    end

    assign bus.arg_rdy  = arg_rdy;
    assign bus.out_vld  = !empty;
    assign bus.out_data = mem_q[rd_ptr_q[AW-1:0]];

`ifdef FORMULA_COLLECTOR_CHECK_EN
    logic [CW-1:0] inflight_q, inflight_d;
    logic          overflow_q, overflow_d;
    logic          proto_err_q, proto_err_d;
    logic          drop, bad_arg, bad_res;

    always_comb begin
        drop     = bus.res_vld & full & !pop;
        bad_arg  = bus.arg_vld & !arg_rdy;
        bad_res  = bus.res_vld & (inflight_q == '0);
        inflight_d = inflight_q;
        // a stray beat with nothing in flight must not wrap the counter
        if (launch && !bus.res_vld)
            inflight_d = inflight_q + CW'(1);
        else if (!launch && bus.res_vld && inflight_q != '0)
            inflight_d = inflight_q - CW'(1);
        overflow_d  = overflow_q | drop;
        proto_err_d = proto_err_q | bad_arg | bad_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q  <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.proto_err = proto_err_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.proto_err = 1'b0;
`endif
endmodule
